// File: rtl/rng_pkg.sv
// Shared definitions for the range sampler: default word width, FSM states,
// and the MSB-smear helper that builds the rejection mask.
package rng_pkg;

  localparam int RNG_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Sets every bit below the highest set bit, so the result covers v exactly.
  function automatic logic [RNG_W-1:0] msb_smear(input logic [RNG_W-1:0] v);
    logic [RNG_W-1:0] m;
    m = v;
    for (int s = 1; s < RNG_W; s = s * 2) begin
      m = m | (m >> s);
    end
    return m;
  endfunction

endpackage

// File: rtl/rng_mask_gen.sv
// Combinational mask builder: the smallest all-ones mask covering range-1.
// range 0 stands for 2^W, so range-1 wraps to all ones and the mask accepts everything.
module rng_mask_gen
  import rng_pkg::*;
#(
  parameter int W = RNG_W
) (
  input  logic [W-1:0] range_i,
  output logic [W-1:0] mask_o,
  output logic         range_is_zero_o
);

  logic [W-1:0] r1;

  assign r1              = range_i - W'(1);
  assign range_is_zero_o = (range_i == '0);

  if (W == RNG_W) begin : g_pkg_smear
    assign mask_o = msb_smear(r1);
  end else begin : g_local_smear
    always_comb begin
      mask_o = r1;
      for (int s = 1; s < W; s = s * 2) begin
        mask_o = mask_o | (mask_o >> s);
      end
    end
  end

endmodule

// File: rtl/rng_range.sv
// Mask-and-reject sampler: turns generator words into unbiased integers in
// [0, range), pulsing rng_start once for every word it consumes.
module rng_range
  import rng_pkg::*;
#(
  parameter int W    = RNG_W,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [W-1:0]    req_range,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  input  logic            rng_valid,
  input  logic [W-1:0]    rng_data,
  output logic            rng_start,
  output logic [CNTW-1:0] reject_cnt
);

  state_e          state_q, state_d;
  logic [W-1:0]    range_q, range_d;
  logic [W-1:0]    mask_q, mask_d;
  logic            range_zero_q, range_zero_d;
  logic [W-1:0]    cand_q, cand_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            req_ready_q, req_ready_d;
  logic            rng_start_q, rng_start_d;
  logic [CNTW-1:0] reject_cnt_q, reject_cnt_d;

  logic [W-1:0]    req_mask;
  logic            req_range_zero;

  rng_mask_gen #(.W(W)) u_mask_gen (
    .range_i         (req_range),
    .mask_o          (req_mask),
    .range_is_zero_o (req_range_zero)
  );

  // NOTE: every variable gets its hold value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    range_d      = range_q;
    mask_d       = mask_q;
    range_zero_d = range_zero_q;
    cand_d       = cand_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    reject_cnt_d = reject_cnt_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          range_d      = req_range;
          mask_d       = req_mask;
          range_zero_d = req_range_zero;
          state_d      = FETCH;
        end
      end
      FETCH: begin
        // rng_data is only meaningful while rng_valid is high.
        if (rng_valid) begin
          cand_d  = rng_data & mask_q;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (range_zero_q || (cand_q < range_q)) begin
          out_data_d  = cand_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          if (reject_cnt_q != '1) begin
            reject_cnt_d = reject_cnt_q + CNTW'(1);
          end
          state_d = FETCH;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered from the next state so the pulse lines up with the CHECK cycle.
    req_ready_d = (state_d == IDLE);
    rng_start_d = (state_d == CHECK);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      range_q      <= '0;
      mask_q       <= '0;
      range_zero_q <= 1'b0;
      cand_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      req_ready_q  <= 1'b1;
      rng_start_q  <= 1'b0;
      reject_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      range_q      <= range_d;
      mask_q       <= mask_d;
      range_zero_q <= range_zero_d;
      cand_q       <= cand_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      req_ready_q  <= req_ready_d;
      rng_start_q  <= rng_start_d;
      reject_cnt_q <= reject_cnt_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign rng_start  = rng_start_q;
  assign reject_cnt = reject_cnt_q;

endmodule

// File: tb/tb_rng_range.sv
// Self-checking bench for rng_range: behavioural generator model, result
// scoreboard, vector table and directed sequences for the multi-cycle corners.
module tb_rng_range;

  localparam int W    = 32;
  localparam int CNTW = 10;
  localparam int SAT  = (1 << CNTW) - 1;
  localparam int HIST_N = 4800;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [W-1:0]    req_range;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic            rng_valid;
  logic [W-1:0]    rng_data;
  logic            rng_start;
  logic [CNTW-1:0] reject_cnt;

  always #5 clk = ~clk;

  rng_range #(.W(W), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_range  (req_range),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .rng_valid  (rng_valid),
    .rng_data   (rng_data),
    .rng_start  (rng_start),
    .reject_cnt (reject_cnt)
  );

  typedef struct {
    logic [W-1:0] bound;
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    int           nw;
    logic [W-1:0] exp_data;
    int           exp_rej;
  } vec_t;

  vec_t         vecs[9];
  logic [W-1:0] gen_q[$];
  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_miss = 0;
  int           gen_delay = 0;
  int           out_count = 0;
  int           start_count = 0;
  int           adj_err = 0;
  bit           prev_start = 1'b0;
  bit           hist_on = 1'b0;
  int           hist[6];
  int           exp_rej = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic summary_and_finish();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  endtask

  task automatic abort(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: timed out at %0t", name, $time);
    summary_and_finish();
  endtask

  // Reference mask: highest set bit of range-1 found by scanning, not smearing.
  function automatic logic [W-1:0] ref_mask(input logic [W-1:0] r);
    logic [W-1:0] r1;
    logic [W-1:0] m;
    r1 = r - W'(1);
    m  = '0;
    for (int i = 0; i < W; i++) begin
      if (r1[i]) m = {W{1'b1}} >> (W - 1 - i);
    end
    return m;
  endfunction

  function automatic bit ref_accept(input logic [W-1:0] r, input logic [W-1:0] w,
                                    output logic [W-1:0] v);
    v = w & ref_mask(r);
    return (r == '0) || (v < r);
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > SAT) ? SAT : a + b;
  endfunction

  // Queue random words until one is accepted; record the expected result.
  task automatic gen_req_words(input logic [W-1:0] r);
    logic [W-1:0] w;
    logic [W-1:0] v;
    bit           acc;
    do begin
      w   = $urandom;
      gen_q.push_back(w);
      acc = ref_accept(r, w, v);
      if (!acc) exp_rej = sat_add(exp_rej, 1);
    end while (!acc);
    exp_q.push_back(v);
  endtask

  // Generator model: word held until a start; valid drops the cycle after it.
  initial begin
    bit st;
    bit rs;
    int cnt;
    rng_valid = 1'b0;
    rng_data  = '0;
    cnt       = 0;
    forever begin
      @(negedge clk);
      st = rng_start;
      rs = rst;
      @(posedge clk);
      #1;
      if (rs) begin
        rng_valid = 1'b0;
        cnt       = 0;
      end else if (st) begin
        rng_valid = 1'b0;
        cnt       = gen_delay;
      end else if (!rng_valid) begin
        if (cnt > 0) cnt--;
        else if (gen_q.size() > 0) begin
          rng_data  = gen_q.pop_front();
          rng_valid = 1'b1;
        end
      end
    end
  end

  // Scoreboard and start-pulse monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", out_data, 64'hx);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
        if (hist_on && out_data < 6) hist[out_data[2:0]]++;
        out_count++;
      end
      if (rng_start) start_count++;
      if (rng_start && prev_start) adj_err++;
      if (rng_start && (req_ready || out_valid)) adj_err++;
    end
    prev_start = rng_start;
  end

  initial begin
    #(95000 * 10);
    abort("watchdog");
  end

  task automatic do_req(input logic [W-1:0] r);
    bit acc;
    int cyc;
    req_range = r;
    req_valid = 1'b1;
    acc       = 1'b0;
    cyc       = 0;
    while (!acc) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (!acc && cyc > 50) abort("req_accept");
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_out(input int oc0, input int budget);
    int cyc;
    cyc = 0;
    while (out_count == oc0) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > budget) abort("out_wait");
    end
  endtask

  task automatic run_req(input logic [W-1:0] r, input int budget);
    int oc0;
    oc0 = out_count;
    do_req(r);
    wait_out(oc0, budget);
  endtask

  initial begin
    int s0;
    int oc0;
    int lat;
    int errs;
    logic [W-1:0] r;

    vecs[0] = '{32'd6,          32'h0000_0007, 32'h1234_5673, 2, 32'd3,          1};
    vecs[1] = '{32'd0,          32'hDEAD_BEEF, 32'h0,         1, 32'hDEAD_BEEF,  0};
    vecs[2] = '{32'd1,          32'hFFFF_FFFF, 32'h0,         1, 32'h0,          0};
    vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1, 32'h7FFF_FFFF,  0};
    vecs[4] = '{32'h8000_0001,  32'hFFFF_FFFF, 32'h5,         2, 32'h5,          1};
    vecs[5] = '{32'd10,         32'h0000_000F, 32'h39,        2, 32'h9,          1};
    vecs[6] = '{32'd10,         32'h0000_000A, 32'h100,       2, 32'h0,          1};
    vecs[7] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 32'hFFFF_FFFE,  1};
    vecs[8] = '{32'd16,         32'hABCD_EF1F, 32'h0,         1, 32'hF,          0};
    for (int i = 0; i < 6; i++) hist[i] = 0;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_range = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready",  req_ready,  1);
    check("rst_out_valid",  out_valid,  0);
    check("rst_out_data",   out_data,   0);
    check("rst_rng_start",  rng_start,  0);
    check("rst_reject_cnt", reject_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 9; i++) begin
      s0 = start_count;
      gen_q.push_back(vecs[i].w0);
      if (vecs[i].nw == 2) gen_q.push_back(vecs[i].w1);
      exp_q.push_back(vecs[i].exp_data);
      exp_rej = sat_add(exp_rej, vecs[i].exp_rej);
      run_req(vecs[i].bound, 100);
      check($sformatf("vec%0d_reject_cnt", i), reject_cnt, exp_rej);
      check($sformatf("vec%0d_starts", i), start_count - s0, vecs[i].nw);
    end

    // Latency with the word already waiting.
    gen_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    lat = 0;
    while (!rng_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("lat_prevalid", rng_valid, 1);
    oc0 = out_count;
    do_req(32'd0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    check("latency_edges", lat, 3);
    wait_out(oc0, 20);

    // Backpressure: result and held generator word must both stay put.
    out_ready = 1'b0;
    gen_q.push_back(32'h55);
    gen_q.push_back(32'h66);
    exp_q.push_back(32'h55);
    oc0 = out_count;
    do_req(32'd0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    check("bp_out_valid", out_valid, 1);
    errs = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_data !== 32'h55 || rng_start !== 1'b0 || req_ready !== 1'b0 ||
          out_valid !== 1'b1 || rng_valid !== 1'b1) errs++;
    end
    check("bp_hold", errs, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_req_ready", req_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    check("bp_one_result", out_count - oc0, 1);

    // Clear the held word, then reset while waiting in FETCH after a reject.
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_rej = 0;
    gen_q.push_back(32'h7);
    do_req(32'd6);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("mid_reject_cnt", reject_cnt, 1);
    check("mid_fetch_rng_valid", rng_valid, 0);
    check("mid_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_req_ready",  req_ready,  1);
    check("midrst_out_valid",  out_valid,  0);
    check("midrst_rng_start",  rng_start,  0);
    check("midrst_reject_cnt", reject_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_rej = 0;

    // Saturating reject counter.
    for (int i = 0; i < (1 << CNTW) + 5; i++) gen_q.push_back(32'h7);
    gen_q.push_back(32'h2);
    exp_q.push_back(32'h2);
    exp_rej = SAT;
    run_req(32'd6, 8000);
    check("sat_reject_cnt", reject_cnt, SAT);

    // Histogram for range 6.
    hist_on = 1'b1;
    for (int i = 0; i < HIST_N; i++) begin
      gen_req_words(32'd6);
      run_req(32'd6, 300);
    end
    hist_on = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("hist_bin%0d_flat", i),
            (hist[i] >= HIST_N / 6 - HIST_N / 50) && (hist[i] <= HIST_N / 6 + HIST_N / 50), 1);
    end

    // Random ranges with a variable generator refill time.
    for (int i = 0; i < 1500; i++) begin
      gen_delay = $urandom_range(0, 2);
      r = $urandom;
      r = r >> $urandom_range(0, 31);
      if (i % 50 == 0) r = '0;
      gen_req_words(r);
      run_req(r, 500);
    end
    gen_delay = 0;

    check("final_reject_cnt", reject_cnt, exp_rej);
    check("start_never_adjacent_or_idle", adj_err, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    summary_and_finish();
  end

endmodule
